// File: rtl/pan_pkg.sv
// Shared PAN constants and the transmit FSM state type, imported by the
// tx, stream and Luhn bridge blocks.
package pan_pkg;

  localparam int PAN_MAX_DIGITS = 19;
  localparam int PAN_MIN_LEN    = 12;
  localparam int PAN_LEN_W      = 5;
  localparam int PAN_NIBBLE_W   = 4;
  localparam int PAN_BCD_MAX    = 9;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DIGIT,
    TX_GAP,
    TX_END
  } tx_state_e;

  function automatic logic is_bcd(input logic [PAN_NIBBLE_W-1:0] nib);
    return (nib <= PAN_NIBBLE_W'(PAN_BCD_MAX));
  endfunction

endpackage

// File: rtl/pan_bcd_check.sv
// Combinational load qualifier: length within [MIN_LEN, MAX_DIGITS] and every
// nibble that will actually be sent is a BCD digit.
module pan_bcd_check
  import pan_pkg::*;
#(
  parameter int MAX_DIGITS = PAN_MAX_DIGITS,
  parameter int MIN_LEN    = PAN_MIN_LEN,
  parameter int LEN_W      = PAN_LEN_W
) (
  input  logic [4*MAX_DIGITS-1:0] i_pan,
  input  logic [LEN_W-1:0]        i_len,
  output logic                    o_load_ok
);

  logic w_digits_ok;
  logic w_len_ok;

  // Nibbles at or beyond the requested length are never transmitted, so skip them.
  always_comb begin
    w_digits_ok = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if ((LEN_W'(k) < i_len) && !is_bcd(i_pan[4*(MAX_DIGITS-1-k) +: 4])) begin
        w_digits_ok = 1'b0;
      end
    end
  end

  assign w_len_ok  = (i_len >= LEN_W'(MIN_LEN)) && (i_len <= LEN_W'(MAX_DIGITS));
  assign o_load_ok = w_len_ok && w_digits_ok;

endmodule

// File: rtl/pan_digit_tx.sv
// Serialises a packed BCD PAN onto the pan_stream input protocol
// (start, digit beats, pan_end, abort); every output is registered.
module pan_digit_tx
  import pan_pkg::*;
#(
  parameter int MAX_DIGITS = PAN_MAX_DIGITS,
  parameter int MIN_LEN    = PAN_MIN_LEN,
  parameter int GAP        = 0,
  parameter int LEN_W      = PAN_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*MAX_DIGITS-1:0] pan_in,
  input  logic [LEN_W-1:0]        len_in,
  input  logic                    abort_req,
  output logic                    ready,
  output logic                    busy,
  output logic                    start,
  output logic                    digit_valid,
  output logic [3:0]              digit_in,
  output logic                    pan_end,
  output logic                    abort,
  output logic                    done,
  output logic                    err,
  output logic [LEN_W-1:0]        digits_sent
);

  localparam int PAN_W = 4 * MAX_DIGITS;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  tx_state_e        r_state;
  logic [PAN_W-1:0] r_pan;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_ready;
  logic             r_busy;
  logic             r_start;
  logic             r_dv;
  logic [3:0]       r_digit;
  logic             r_pan_end;
  logic             r_abort;
  logic             r_done;
  logic             r_err;

  logic             w_load_ok;
  logic             w_accept;
  logic             w_beat;
  logic [LEN_W-1:0] w_next_cnt;
  logic             w_last;

  pan_bcd_check #(
    .MAX_DIGITS (MAX_DIGITS),
    .MIN_LEN    (MIN_LEN),
    .LEN_W      (LEN_W)
  ) u_check (
    .i_pan     (pan_in),
    .i_len     (len_in),
    .o_load_ok (w_load_ok)
  );

  assign w_accept   = (r_state == TX_IDLE) && r_ready && load && w_load_ok;
  assign w_beat     = (r_state == TX_DIGIT) && !abort_req;
  assign w_next_cnt = r_cnt + LEN_W'(1);
  assign w_last     = (w_next_cnt == r_len);

  // Latched PAN shifts left one nibble per beat so the next digit is always on top.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_pan <= pan_in;
      r_len <= len_in;
    end else if (w_beat) begin
      r_pan <= r_pan << 4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_dv      <= 1'b0;
      r_digit   <= '0;
      r_pan_end <= 1'b0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_dv      <= 1'b0;
      r_digit   <= '0;
      r_pan_end <= 1'b0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (w_accept) begin
            r_state <= TX_START;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            // ready/busy settle here one cycle after pan_end or abort.
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= r_ready && load;
          end
        end
        TX_START: begin
          if (abort_req) begin
            r_abort <= 1'b1;
            r_state <= TX_IDLE;
          end else begin
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= TX_DIGIT;
          end
        end
        TX_DIGIT: begin
          if (abort_req) begin
            r_abort <= 1'b1;
            r_state <= TX_IDLE;
          end else begin
            r_dv      <= 1'b1;
            r_digit   <= r_pan[PAN_W-1 -: 4];
            r_cnt     <= w_next_cnt;
            r_gap_cnt <= '0;
            if (w_last) begin
              r_state <= TX_END;
            end else if (GAP > 0) begin
              r_state <= TX_GAP;
            end
          end
        end
        TX_GAP: begin
          if (abort_req) begin
            r_abort <= 1'b1;
            r_state <= TX_IDLE;
          end else if (r_gap_cnt == GAP_W'(GAP - 1)) begin
            r_state <= TX_DIGIT;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        TX_END: begin
          r_pan_end <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= TX_IDLE;
        end
        default: begin
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign busy        = r_busy;
  assign start       = r_start;
  assign digit_valid = r_dv;
  assign digit_in    = r_digit;
  assign pan_end     = r_pan_end;
  assign abort       = r_abort;
  assign done        = r_done;
  assign err         = r_err;
  assign digits_sent = r_cnt;

endmodule

// File: tb/tb_pan_digit_tx.sv
// Directed bench for pan_digit_tx: one instance with GAP=0 and one with GAP=2,
// expected strobes per cycle derived from the frame timing formulas.
module tb_pan_digit_tx;

  localparam int MD = 19;
  localparam int LW = 5;
  localparam int PW = 4 * MD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    load;
  logic [PW-1:0] pan_in;
  logic [LW-1:0] len_in;
  logic          abort_req;

  logic [1:0]    ready, busy, start, dv, pend, abort, done, err;
  logic [3:0]    digit [2];
  logic [LW-1:0] dsent [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pan_digit_tx #(.MAX_DIGITS(MD), .MIN_LEN(12), .GAP(0), .LEN_W(LW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load[0]), .pan_in(pan_in), .len_in(len_in),
    .abort_req(abort_req), .ready(ready[0]), .busy(busy[0]), .start(start[0]),
    .digit_valid(dv[0]), .digit_in(digit[0]), .pan_end(pend[0]), .abort(abort[0]),
    .done(done[0]), .err(err[0]), .digits_sent(dsent[0])
  );

  pan_digit_tx #(.MAX_DIGITS(MD), .MIN_LEN(12), .GAP(2), .LEN_W(LW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load[1]), .pan_in(pan_in), .len_in(len_in),
    .abort_req(abort_req), .ready(ready[1]), .busy(busy[1]), .start(start[1]),
    .digit_valid(dv[1]), .digit_in(digit[1]), .pan_end(pend[1]), .abort(abort[1]),
    .done(done[1]), .err(err[1]), .digits_sent(dsent[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] obs(input int s);
    return {ready[s], busy[s], start[s], dv[s], digit[s], pend[s], done[s], abort[s], err[s]};
  endfunction

  function automatic logic [11:0] vec(input logic rdy, input logic bsy, input logic st,
                                      input logic v, input logic [3:0] d, input logic pe,
                                      input logic dn, input logic ab, input logic er);
    return {rdy, bsy, st, v, d, pe, dn, ab, er};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one accepted frame; abort_at / midload_at are the edge numbers at
  // which abort_req / a stray load are sampled (0 = never).
  task automatic run_frame(input string name, input int s, input logic [PW-1:0] pan,
                           input int len, input int gap, input int abort_at,
                           input int midload_at);
    int last;
    last = 2 + len * (gap + 1) - gap;
    pan_in  = pan;
    len_in  = LW'(len);
    load[s] = 1'b1;
    tick();
    load[s] = 1'b0;
    pan_in  = '1;
    len_in  = '0;
    chk($sformatf("%s acc", name), 32'(obs(s)), 32'(vec(0, 1, 0, 0, 4'h0, 0, 0, 0, 0)));
    for (int c = 1; c <= last + 1; c++) begin
      logic [11:0] e;
      logic        dvx;
      logic [3:0]  dx;
      int          k;
      if (c == midload_at) begin
        load[s] = 1'b1;
        len_in  = 5'd3;
      end
      if (c == abort_at) abort_req = 1'b1;
      tick();
      load[s]   = 1'b0;
      abort_req = 1'b0;
      if (abort_at > 0 && c == abort_at) begin
        e = vec(0, 1, 0, 0, 4'h0, 0, 0, 1, 0);
      end else if (abort_at > 0 && c == abort_at + 1) begin
        chk($sformatf("%s c%0d", name, c), 32'(obs(s)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));
        break;
      end else begin
        dvx = 1'b0;
        dx  = 4'h0;
        if (c >= 2 && ((c - 2) % (gap + 1)) == 0 && ((c - 2) / (gap + 1)) < len) begin
          k   = (c - 2) / (gap + 1);
          dvx = 1'b1;
          dx  = pan[PW-1-4*k -: 4];
        end
        e = vec(c > last, c <= last, c == 1, dvx, dx, c == last, c == last, 0, 0);
      end
      chk($sformatf("%s c%0d", name, c), 32'(obs(s)), 32'(e));
    end
  endtask

  task automatic reject(input string name, input logic [PW-1:0] pan, input int len);
    pan_in  = pan;
    len_in  = LW'(len);
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    chk($sformatf("%s err", name), 32'(obs(0)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 1)));
    tick();
    chk($sformatf("%s after", name), 32'(obs(0)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));
  endtask

  initial begin
    logic [PW-1:0] pan16;
    pan16     = {64'h4111_1111_1111_1111, 12'h000};
    rst_n     = 1'b0;
    load      = 2'b00;
    abort_req = 1'b0;
    pan_in    = '0;
    len_in    = '0;
    #12;
    chk("reset0", 32'(obs(0)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));
    chk("reset1", 32'(obs(1)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));
    chk("reset dsent", 32'(dsent[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    run_frame("t1", 0, pan16, 16, 0, 0, 0);
    chk("t1 dsent", 32'(dsent[0]), 32'd16);

    reject("t2 len11", {MD{4'h1}}, 11);
    reject("t2 len20", {MD{4'h1}}, 20);

    reject("t3 badnib", 76'h12345A7890123_FFFFFF, 13);
    reject("t3 len5", 76'h12345A7890123_FFFFFF, 5);
    run_frame("t3 ok", 0, 76'h1234567890123_FFFFFF, 13, 0, 0, 0);
    chk("t3 dsent", 32'(dsent[0]), 32'd13);

    run_frame("t4", 1, 76'h123456789012_FFFFFFF, 12, 2, 0, 0);
    chk("t4 dsent", 32'(dsent[1]), 32'd12);

    run_frame("t5", 0, pan16, 16, 0, 9, 5);
    chk("t5 dsent", 32'(dsent[0]), 32'd7);
    tick();
    chk("t5 quiet", 32'(obs(0)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));

    pan_in  = 76'h123456789012_FFFFFFF;
    len_in  = 5'd12;
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    tick();
    tick();
    tick();
    chk("t6 gap", 32'(obs(1)), 32'(vec(0, 1, 0, 0, 4'h0, 0, 0, 0, 0)));
    #2 rst_n = 1'b0;
    #1;
    chk("t6 rst", 32'(obs(1)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));
    chk("t6 rst dsent", 32'(dsent[1]), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("t6 rel", 32'(obs(1)), 32'(vec(1, 0, 0, 0, 4'h0, 0, 0, 0, 0)));
    run_frame("t6 f19", 0, 76'h4539578763621486123, 19, 0, 0, 0);
    chk("t6 dsent", 32'(dsent[0]), 32'd19);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
